// File: rtl/pll_lock_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_lock_reset_seq
//
// Sequences the PLL reset and the DDR3 controller-domain reset from a
// free-running board clock. The PLL is held in reset for a fixed pulse. The
// block then waits for LOCKED, qualifies it over a stable window, and waits a
// release delay before it deasserts the controller reset. A lock loss while
// running puts the controller back into reset and returns to waiting for lock.
//
// Optional feature (compile-time macro PLL_LOCK_TIMEOUT_EN):
//   When defined, WAIT_LOCK gives up after LOCK_TIMEOUT_CYCLES cycles without
//   lock and re-pulses the PLL reset. When undefined, WAIT_LOCK waits forever.
//
// Ports:
//   i_clk              free-running board clock (not PLL-derived)
//   i_rst_n            asynchronous active-low reset
//   i_pll_locked       PLL LOCKED, asynchronous to i_clk
//   i_soft_rst         synchronous one-cycle request to restart the sequence
//   o_pll_reset        active-high PLL reset (registered)
//   o_rst_n            active-low controller-domain reset (registered)
//   o_run_pulse        one-cycle pulse on the first cycle in RUN (registered)
//   o_lock_loss_count  saturating count of lock losses seen in RUN
//   o_state            current state: 0 PLL_RST, 1 WAIT_LOCK, 2 STABLE,
//                      3 RELEASE, 4 RUN
// -----------------------------------------------------------------------------
module pll_lock_reset_seq #(
  parameter int unsigned LOCK_STABLE_CYCLES   = 1024,
  parameter int unsigned RELEASE_DELAY_CYCLES = 16,
  parameter int unsigned PLL_RST_CYCLES       = 8,
  parameter int unsigned LOCK_TIMEOUT_CYCLES  = 65536
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pll_locked,
  input  logic       i_soft_rst,
  output logic       o_pll_reset,
  output logic       o_rst_n,
  output logic       o_run_pulse,
  output logic [7:0] o_lock_loss_count,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  // Terminal counts: a state lasting N cycles leaves when the counter,
  // which starts at 0 on entry, reads N-1.
  localparam logic [19:0] PLL_RST_LAST = 20'(PLL_RST_CYCLES - 1);
  localparam logic [19:0] STABLE_LAST  = 20'(LOCK_STABLE_CYCLES - 1);
  localparam logic [19:0] RELEASE_LAST = 20'(RELEASE_DELAY_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [19:0] CNT_MAX      = 20'hFFFFF;
  localparam logic [7:0]  LOSS_MAX     = 8'hFF;

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  logic        lock_meta_p0;
  logic        locked_s;
  state_t      state;
  state_t      state_nxt;
  logic [19:0] cnt;
  logic [19:0] cnt_nxt;
  logic        loss_evt;

  // Two-flop synchronizer for the asynchronous LOCKED input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_meta_p0 <= 1'b0;
      locked_s     <= 1'b0;
    end else begin
      lock_meta_p0 <= i_pll_locked;
      locked_s     <= lock_meta_p0;
    end
  end

  // Next-state logic. A soft reset overrides every other decision, so a lock
  // loss on the same cycle is neither acted on nor counted.
  always_comb begin
    state_nxt = state;
    loss_evt  = 1'b0;
    if (i_soft_rst) begin
      state_nxt = ST_PLL_RST;
    end else begin
      case (state)
        ST_PLL_RST: begin
          if (cnt == PLL_RST_LAST) state_nxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (locked_s) state_nxt = ST_STABLE;
          else if (TIMEOUT_EN && (cnt == TIMEOUT_LAST)) state_nxt = ST_PLL_RST;
        end
        ST_STABLE: begin
          if (!locked_s) state_nxt = ST_WAIT_LOCK;
          else if (cnt == STABLE_LAST) state_nxt = ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!locked_s) state_nxt = ST_WAIT_LOCK;
          else if (cnt == RELEASE_LAST) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_nxt = ST_WAIT_LOCK;
            loss_evt  = 1'b1;
          end
        end
        default: state_nxt = ST_PLL_RST;
      endcase
    end
  end

  // Shared cycle counter: cleared on every state change (and on a soft reset,
  // so a soft reset issued inside PLL_RST restarts the full pulse). It holds
  // at its maximum instead of wrapping while the block idles in WAIT_LOCK or RUN.
  always_comb begin
    cnt_nxt = cnt;
    if (i_soft_rst || (state_nxt != state)) cnt_nxt = '0;
    else if (cnt != CNT_MAX)                cnt_nxt = cnt + 20'd1;
  end

  // State, counter and registered outputs. The outputs are decoded from the
  // next state, so o_rst_n and o_pll_reset switch on the same edge as the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state             <= ST_PLL_RST;
      cnt               <= '0;
      o_pll_reset       <= 1'b1;
      o_rst_n           <= 1'b0;
      o_run_pulse       <= 1'b0;
      o_lock_loss_count <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      o_pll_reset <= (state_nxt == ST_PLL_RST);
      o_rst_n     <= (state_nxt == ST_RUN);
      o_run_pulse <= (state_nxt == ST_RUN) && (state != ST_RUN);
      if (loss_evt && (o_lock_loss_count != LOSS_MAX)) begin
        o_lock_loss_count <= o_lock_loss_count + 8'd1;
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_reset_seq
//
// Bench for pll_lock_reset_seq with LOCK_STABLE=8, RELEASE_DELAY=4,
// PLL_RST=3, LOCK_TIMEOUT=32. Stimulus pushes each expected state transition
// (edge number, state and output values) into a queue. A monitor pops one
// entry every time o_state changes and compares it with the DUT. Edge numbers
// count rising clock edges from time zero.
// -----------------------------------------------------------------------------
module tb_pll_lock_reset_seq;

  localparam int LS  = 8;
  localparam int RD  = 4;
  localparam int PRC = 3;
  localparam int TO  = 32;

  localparam logic [2:0] S_PR  = 3'd0;
  localparam logic [2:0] S_WL  = 3'd1;
  localparam logic [2:0] S_ST  = 3'd2;
  localparam logic [2:0] S_RL  = 3'd3;
  localparam logic [2:0] S_RUN = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_rst;
  logic       pll_reset;
  logic       ctl_rst_n;
  logic       run_pulse;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int edge_n   = 0;
  int checks   = 0;
  int errors   = 0;
  int run_seen = 0;
  int exp_cnt  = 0;

  typedef struct {
    int         edge_no;
    logic [2:0] st;
    logic       rst_n;
    logic       pll;
    logic       run;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  logic [2:0] prev_st  = 3'd0;
  logic       prev_run = 1'b0;

  pll_lock_reset_seq #(
    .LOCK_STABLE_CYCLES   (LS),
    .RELEASE_DELAY_CYCLES (RD),
    .PLL_RST_CYCLES       (PRC),
    .LOCK_TIMEOUT_CYCLES  (TO)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_pll_locked      (pll_locked),
    .i_soft_rst        (soft_rst),
    .o_pll_reset       (pll_reset),
    .o_rst_n           (ctl_rst_n),
    .o_run_pulse       (run_pulse),
    .o_lock_loss_count (loss_cnt),
    .o_state           (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n++;

  // Monitor: one scoreboard entry per state change while out of reset.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_st = state;
    end else if (state != prev_st) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_transition: got st=%0d at edge %0d, required no transition",
                 state, edge_n);
      end else begin
        e = exp_q.pop_front();
        if (state !== e.st || ctl_rst_n !== e.rst_n || pll_reset !== e.pll ||
            run_pulse !== e.run || loss_cnt !== e.cnt || edge_n != e.edge_no) begin
          errors++;
          $display("FAIL transition: got st=%0d rst_n=%0b pll=%0b run=%0b cnt=%0d edge=%0d, required st=%0d rst_n=%0b pll=%0b run=%0b cnt=%0d edge=%0d",
                   state, ctl_rst_n, pll_reset, run_pulse, loss_cnt, edge_n,
                   e.st, e.rst_n, e.pll, e.run, e.cnt, e.edge_no);
        end
      end
      prev_st = state;
    end
    if (prev_run) begin
      checks++;
      if (run_pulse !== 1'b0) begin
        errors++;
        $display("FAIL run_pulse_width: got run_pulse=%0b on 2nd cycle at edge %0d, required 0",
                 run_pulse, edge_n);
      end
    end
    if (run_pulse === 1'b1 && !prev_run) run_seen++;
    prev_run = (run_pulse === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_push(input int e, input logic [2:0] s, input logic r,
                          input logic p, input logic u, input int c);
    exp_t x;
    x.edge_no = e;
    x.st      = s;
    x.rst_n   = r;
    x.pll     = p;
    x.run     = u;
    x.cnt     = 8'(c);
    exp_q.push_back(x);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    checks++;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d pending transitions after %0d cycles, required 0",
               tag, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  initial begin
    int   n0;
    int   m0;
    int   r0;
    int   rises;
    int   exp_rises;
    logic prev_p;

    rst_n      = 1'b0;
    pll_locked = 1'b0;
    soft_rst   = 1'b0;
    tick(2);

    // Reset state.
    chk("reset_state",     int'(state),     int'(S_PR));
    chk("reset_pll_reset", int'(pll_reset), 1);
    chk("reset_rst_n",     int'(ctl_rst_n), 0);
    chk("reset_run_pulse", int'(run_pulse), 0);
    chk("reset_loss_cnt",  int'(loss_cnt),  0);

    // Power-up: PLL reset 3 cycles, lock from cycle 10, RUN 14 edges after capture.
    r0 = edge_n;
    rst_n = 1'b1;
    exp_push(r0 + PRC, S_WL, 1'b0, 1'b0, 1'b0, 0);
    tick(9);
    n0 = edge_n;
    pll_locked = 1'b1;
    exp_push(n0 + 3,           S_ST,  1'b0, 1'b0, 1'b0, 0);
    exp_push(n0 + 3 + LS,      S_RL,  1'b0, 1'b0, 1'b0, 0);
    exp_push(n0 + 3 + LS + RD, S_RUN, 1'b1, 1'b0, 1'b1, 0);
    wait_drain("power_up", 40);
    tick(2);
    chk("run_pulse_count_power_up", run_seen, 1);
    chk("rst_n_in_run", int'(ctl_rst_n), 1);

    // Lock loss in RUN, then a one-cycle glitch during STABLE qualification.
    n0 = edge_n;
    pll_locked = 1'b0;
    exp_cnt = sat_inc(exp_cnt);
    exp_push(n0 + 3, S_WL, 1'b0, 1'b0, 1'b0, exp_cnt);
    wait_drain("loss_first", 10);
    m0 = edge_n;
    pll_locked = 1'b1;
    exp_push(m0 + 3,  S_ST,  1'b0, 1'b0, 1'b0, exp_cnt);
    exp_push(m0 + 8,  S_WL,  1'b0, 1'b0, 1'b0, exp_cnt);
    exp_push(m0 + 9,  S_ST,  1'b0, 1'b0, 1'b0, exp_cnt);
    exp_push(m0 + 17, S_RL,  1'b0, 1'b0, 1'b0, exp_cnt);
    exp_push(m0 + 21, S_RUN, 1'b1, 1'b0, 1'b1, exp_cnt);
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    wait_drain("glitch", 40);

    // Soft reset on the same cycle locked_s falls: no count, full PLL pulse.
    tick(2);
    n0 = edge_n;
    pll_locked = 1'b0;
    exp_push(n0 + 3,       S_PR, 1'b0, 1'b1, 1'b0, exp_cnt);
    exp_push(n0 + 3 + PRC, S_WL, 1'b0, 1'b0, 1'b0, exp_cnt);
    tick(2);
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    wait_drain("soft_rst", 20);
    chk("loss_cnt_after_soft_rst", int'(loss_cnt), exp_cnt);
    m0 = edge_n;
    pll_locked = 1'b1;
    exp_push(m0 + 3,           S_ST,  1'b0, 1'b0, 1'b0, exp_cnt);
    exp_push(m0 + 3 + LS,      S_RL,  1'b0, 1'b0, 1'b0, exp_cnt);
    exp_push(m0 + 3 + LS + RD, S_RUN, 1'b1, 1'b0, 1'b1, exp_cnt);
    wait_drain("relock", 40);

    // 300 lock losses in RUN; rst_n falls 2 edges after capture, count saturates.
    for (int i = 0; i < 300; i++) begin
      tick(2);
      n0 = edge_n;
      pll_locked = 1'b0;
      exp_cnt = sat_inc(exp_cnt);
      exp_push(n0 + 3,       S_WL,  1'b0, 1'b0, 1'b0, exp_cnt);
      exp_push(n0 + 4,       S_ST,  1'b0, 1'b0, 1'b0, exp_cnt);
      exp_push(n0 + 4 + LS,  S_RL,  1'b0, 1'b0, 1'b0, exp_cnt);
      exp_push(n0 + 16,      S_RUN, 1'b1, 1'b0, 1'b1, exp_cnt);
      tick(1);
      pll_locked = 1'b1;
      wait_drain("loss_loop", 30);
    end
    chk("loss_cnt_saturated", int'(loss_cnt), 255);
    chk("run_pulse_count_total", run_seen, 303);

    // Asynchronous reset in the middle of RELEASE.
    tick(2);
    n0 = edge_n;
    pll_locked = 1'b0;
    exp_push(n0 + 3,      S_WL, 1'b0, 1'b0, 1'b0, exp_cnt);
    exp_push(n0 + 4,      S_ST, 1'b0, 1'b0, 1'b0, exp_cnt);
    exp_push(n0 + 4 + LS, S_RL, 1'b0, 1'b0, 1'b0, exp_cnt);
    tick(1);
    pll_locked = 1'b1;
    wait_drain("to_release", 30);
    chk("state_before_async_rst", int'(state), int'(S_RL));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state",     int'(state),     int'(S_PR));
    chk("async_rst_rst_n",     int'(ctl_rst_n), 0);
    chk("async_rst_pll_reset", int'(pll_reset), 1);
    chk("async_rst_loss_cnt",  int'(loss_cnt),  0);
    chk("async_rst_run_pulse", int'(run_pulse), 0);
    exp_cnt = 0;

    // Lock held low after reset: one PLL pulse, or periodic re-pulses with timeout.
    pll_locked = 1'b0;
    tick(2);
    r0 = edge_n;
    rst_n = 1'b1;
    exp_push(r0 + PRC, S_WL, 1'b0, 1'b0, 1'b0, 0);
`ifdef PLL_LOCK_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      exp_push(r0 + PRC + TO + (PRC + TO) * k,       S_PR, 1'b0, 1'b1, 1'b0, 0);
      exp_push(r0 + PRC + TO + (PRC + TO) * k + PRC, S_WL, 1'b0, 1'b0, 1'b0, 0);
    end
    exp_rises = 3;
`else
    exp_rises = 0;
`endif
    tick(4);
    prev_p = pll_reset;
    rises  = 0;
    for (int k = 0; k < 106; k++) begin
      tick(1);
      if (pll_reset === 1'b1 && prev_p !== 1'b1) rises++;
      prev_p = pll_reset;
    end
    chk("pll_reset_repulses", rises, exp_rises);
    wait_drain("no_lock", 10);
    chk("final_state", int'(state), int'(S_WL));
    chk("final_pll_reset", int'(pll_reset), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_reset_seq.md
PLL_LOCK_RESET_SEQ -- requirements
Module: pll_lock_reset_seq

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before reset release begins (range 2..65535).
REQ-002 SHALL have parameter RELEASE_DELAY_CYCLES, default 16: cycles between lock qualification and controller reset deassertion (range 1..65535).
REQ-003 SHALL have parameter PLL_RST_CYCLES, default 8: width of the PLL reset pulse (range 1..65535).
REQ-004 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: maximum cycles spent waiting for lock before the PLL is re-reset (range 2..2^20).
REQ-005 SHALL have port i_clk, input, 1: free-running board clock that does not come from the PLL.
REQ-006 SHALL have port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port i_pll_locked, input, 1: PLL LOCKED, asynchronous to i_clk.
REQ-008 SHALL have port i_soft_rst, input, 1: synchronous one-cycle request to restart the full sequence.
REQ-009 SHALL have port o_pll_reset, output, 1: active-high reset to the PLL RST pin.
REQ-010 SHALL have port o_rst_n, output, 1: active-low reset to the DDR3 controller domain.
REQ-011 SHALL have port o_run_pulse, output, 1: one-cycle pulse on entry to RUN.
REQ-012 SHALL have port o_lock_loss_count, output, 8: saturating count of lock losses seen in RUN.
REQ-013 SHALL have port o_state, output, 3: current state encoding.

Function
REQ-014 SHALL synchronize i_pll_locked through two flops to give locked_s; all decisions use locked_s only.
REQ-015 SHALL implement the states PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3 and RUN=4, with a single shared 20-bit cycle counter that clears on every state change.
REQ-016 In PLL_RST, the block SHALL hold o_pll_reset=1 for exactly PLL_RST_CYCLES cycles and then move to WAIT_LOCK.
REQ-017 In WAIT_LOCK, locked_s=1 SHALL move the block to STABLE.
REQ-018 In STABLE, the block SHALL move to RELEASE after LOCK_STABLE_CYCLES consecutive cycles of locked_s=1, and locked_s=0 SHALL return it to WAIT_LOCK.
REQ-019 In RELEASE, the block SHALL move to RUN after RELEASE_DELAY_CYCLES cycles, and locked_s=0 SHALL return it to WAIT_LOCK.
REQ-020 In RUN, locked_s=0 SHALL move the block to WAIT_LOCK and increment o_lock_loss_count, saturating at 255.
REQ-021 o_rst_n SHALL be registered and equal 1 only while the state is RUN; it SHALL fall on the same edge as the transition out of RUN.
REQ-022 o_run_pulse SHALL be registered and asserted for exactly the first cycle in RUN.
REQ-023 Capture latency: if edge 0 is the edge at which the first sync flop captures i_pll_locked=1, then o_rst_n SHALL rise after edge 2+LOCK_STABLE_CYCLES+RELEASE_DELAY_CYCLES, provided the lock stays stable.
REQ-024 Loss latency: if a lock drop in RUN is captured at edge 0, then o_rst_n SHALL be 0 after edge 2.
REQ-025 i_soft_rst=1 SHALL force PLL_RST from any state on the next edge and SHALL take priority over lock loss; a lock loss on that same cycle SHALL NOT be counted.
REQ-026 A lock glitch shorter than LOCK_STABLE_CYCLES in STABLE SHALL restart qualification from zero; the block SHALL NOT carry partial credit.

Reset
REQ-027 While i_rst_n=0 (asynchronous assert), the block SHALL hold state=PLL_RST, counter=0, sync flops=0, o_pll_reset=1, o_rst_n=0, o_run_pulse=0 and o_lock_loss_count=0.
REQ-028 After i_rst_n deasserts, the block SHALL run a full PLL_RST pulse of PLL_RST_CYCLES cycles; reset mid-sequence SHALL restart from PLL_RST.

Configuration
REQ-029 With PLL_LOCK_TIMEOUT_EN defined, WAIT_LOCK SHALL move to PLL_RST after LOCK_TIMEOUT_CYCLES cycles without locked_s=1, and the timeout counter SHALL restart on each WAIT_LOCK entry.
REQ-030 Without PLL_LOCK_TIMEOUT_EN, WAIT_LOCK SHALL wait indefinitely, and o_pll_reset SHALL assert only in PLL_RST entered via reset or i_soft_rst.

Verification (parameters 8/4/3/32 for LOCK_STABLE/RELEASE_DELAY/PLL_RST/LOCK_TIMEOUT)
REQ-031 Release reset, drive locked=1 from cycle 10 -> o_pll_reset high 3 cycles; o_rst_n rises 14 edges after the capture edge; o_run_pulse one cycle.
REQ-032 In STABLE, drop locked for 1 cycle after 5 good cycles -> return to WAIT_LOCK; o_rst_n rises only after 8 fresh stable cycles plus 4 cycles of delay.
REQ-033 In RUN, drop locked 300 times -> o_rst_n low 2 edges after each capture edge; o_lock_loss_count saturates at 255.
REQ-034 In RUN, pulse i_soft_rst on the same cycle that locked_s falls -> PLL_RST, o_pll_reset high 3 cycles, count unchanged.
REQ-035 With PLL_LOCK_TIMEOUT_EN and locked held 0 -> o_pll_reset re-pulses every 3+32 cycles; without the macro -> exactly one pulse.
REQ-036 Assert i_rst_n low asynchronously mid-RELEASE -> o_rst_n=0, o_pll_reset=1, and count=0 immediately, without waiting for a clock edge.
